// File: rtl/dmem_be_sync.sv
// -----------------------------------------------------------------------------
// dmem_be_sync
//
// Byte-addressed, byte-lane-enabled data memory for the pipelined MIPS core.
// Supports SB/SH/SW stores and LB/LBU/LH/LHU/LW loads with a registered
// one-cycle read and valid strobe. Misaligned or illegal-size accesses are
// rejected and flagged. After reset the whole array is swept to zero while
// busy is held high so the pipeline stalls.
//
// Parameters:
//   DEPTH   number of 32-bit words (power of two, >= 4)
//   ADDR_W  width of the byte address input
//   TEST_W  width of the debug copy of word 0
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-low reset
//   addr       byte address (wraps modulo 4*DEPTH)
//   wdata      store data, right-aligned
//   we / re    store / load request
//   size       00 byte, 01 half, 10 word, 11 illegal
//   sign_ext   sign-extend byte/half loads when 1
//   rdata      registered load result (holds when rvalid is low)
//   rvalid     one-cycle pulse, rdata valid
//   misalign   one-cycle pulse after a rejected access
//   busy       high during reset and the clear sweep
//   test       registered copy of word 0 bits [TEST_W-1:0]
// -----------------------------------------------------------------------------
module dmem_be_sync #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32,
    parameter int TEST_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              we,
    input  logic              re,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              misalign,
    output logic              busy,
    output logic [TEST_W-1:0] test
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              misalign_q, misalign_d;
    logic [TEST_W-1:0] test_q, test_d;

    logic [31:0]       mem_q [DEPTH];

    logic [IDX_W-1:0]  acc_idx;
    logic [1:0]        lane;
    logic              illegal;
    logic              active;
    logic              store_ok;
    logic              load_ok;
    logic [3:0]        lane_mask;
    logic [31:0]       lane_data;
    logic [31:0]       bit_mask;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [31:0]       wr_word;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       load_val;
    logic [31:0]       word0_next;
    logic              unused_ok;

    assign acc_idx = addr[IDX_W+1:2];
    assign lane    = addr[1:0];

    // Upper address bits are intentionally ignored (address wrap), and only
    // part of the shifted read word / next word 0 is consumed.
    assign unused_ok = ^{addr >> (IDX_W + 2), word0_next >> TEST_W, rd_shift >> 16};

    // Alignment rule: halves need addr[0]=0, words need addr[1:0]=00.
    always_comb begin
        illegal = 1'b0;
        case (size)
            2'b00:   illegal = 1'b0;
            2'b01:   illegal = addr[0];
            2'b10:   illegal = |addr[1:0];
            default: illegal = 1'b1;
        endcase
    end

    assign active   = reset && (state_q == IDLE);
    assign store_ok = active && we && !illegal;
    assign load_ok  = active && re && !illegal;

    // Replicating the store data across lanes lets one mask pick the target
    // lanes regardless of where in the word they sit.
    always_comb begin
        lane_mask = 4'b0000;
        lane_data = wdata;
        case (size)
            2'b00: begin
                lane_mask = 4'b0001 << lane;
                lane_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata[15:0]}};
            end
            2'b10: begin
                lane_mask = 4'b1111;
                lane_data = wdata;
            end
            default: begin
                lane_mask = 4'b0000;
                lane_data = wdata;
            end
        endcase
    end

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < 4; i++) begin
            bit_mask[8*i +: 8] = {8{lane_mask[i]}};
        end
    end

    // Single write port shared by the clear sweep and stores; the sweep owns
    // it whenever the FSM is in CLEAR.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = acc_idx;
        wr_word = '0;
        if (reset && (state_q == CLEAR)) begin
            wr_en   = 1'b1;
            wr_idx  = clr_cnt_q;
            wr_word = '0;
        end else if (store_ok) begin
            wr_en   = 1'b1;
            wr_idx  = acc_idx;
            wr_word = (mem_q[acc_idx] & ~bit_mask) | (lane_data & bit_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_word;
        end
    end

    // Read uses the pre-write contents, giving read-before-write when a load
    // and store hit the same word in one cycle. A legal half always has
    // addr[0]=0, so the byte shift also aligns halves.
    assign rd_word  = mem_q[acc_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        load_val = rd_word;
        case (size)
            2'b00:   load_val = {{24{sign_ext & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = {{16{sign_ext & rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
    end

    // The debug port follows word 0 as it will be after this edge's write.
    assign word0_next = (wr_en && (wr_idx == '0)) ? wr_word : mem_q[0];

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        misalign_d = 1'b0;
        test_d     = word0_next[TEST_W-1:0];
        if (!reset) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
            rdata_d   = '0;
            test_d    = '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
                IDLE: begin
                    rvalid_d   = load_ok;
                    misalign_d = (we || re) && illegal;
                    if (load_ok) begin
                        rdata_d = load_val;
                    end
                end
                default: begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q    <= state_d;
        clr_cnt_q  <= clr_cnt_d;
        rdata_q    <= rdata_d;
        rvalid_q   <= rvalid_d;
        misalign_q <= misalign_d;
        test_q     <= test_d;
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign misalign = misalign_q;
    assign busy     = (state_q == CLEAR);
    assign test     = test_q;

endmodule

// File: tb/tb_dmem_be_sync.sv
// -----------------------------------------------------------------------------
// tb_dmem_be_sync
//
// Self-checking bench for dmem_be_sync (DEPTH=16). A byte-array model of the
// memory predicts every output on every cycle; directed sequences add
// hand-computed literal expectations, followed by randomized traffic and a
// reset in the middle of the clear sweep.
// -----------------------------------------------------------------------------
module tb_dmem_be_sync;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
    localparam int TEST_W = 16;
    localparam int NBYTES = 4 * DEPTH;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic              we = 1'b0;
    logic              re = 1'b0;
    logic [1:0]        size = 2'b00;
    logic              sign_ext = 1'b0;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              misalign;
    logic              busy;
    logic [TEST_W-1:0] test;

    int n_cmp  = 0;
    int n_fail = 0;

    dmem_be_sync #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .TEST_W(TEST_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .size    (size),
        .sign_ext(sign_ext),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .misalign(misalign),
        .busy    (busy),
        .test    (test)
    );

    always #5 clk = ~clk;

    // Reference model: memory as a plain byte array, sweep as a countdown.
    logic [7:0]  m [NBYTES];
    int          sweep_left = DEPTH;
    logic        model_live = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic        exp_rvalid = 1'b0;
    logic        exp_mis = 1'b0;

    function automatic logic is_legal(input logic [1:0] sz, input logic [31:0] a);
        int n;
        if (sz == 2'b11) return 1'b0;
        n = 1 << sz;
        return (a % n) == 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [1:0] sz, input logic sx,
                                             input logic [31:0] a);
        int unsigned base;
        int          n;
        logic [31:0] v;
        base = a % NBYTES;
        n    = 1 << sz;
        v    = '0;
        for (int k = 0; k < n; k++) begin
            v = v | (32'(m[(base + k) % NBYTES]) << (8 * k));
        end
        if (sx && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
        if (sx && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // The model updates on the same edge as the DUT, from the inputs held
    // stable across that edge.
    always @(posedge clk) begin
        model_live <= 1'b1;
        if (!reset) begin
            exp_rdata  <= '0;
            exp_rvalid <= 1'b0;
            exp_mis    <= 1'b0;
            sweep_left <= DEPTH;
            for (int k = 0; k < NBYTES; k++) m[k] <= 8'h00;
        end else if (sweep_left != 0) begin
            sweep_left <= sweep_left - 1;
            exp_rvalid <= 1'b0;
            exp_mis    <= 1'b0;
        end else if ((we || re) && !is_legal(size, addr)) begin
            exp_mis    <= 1'b1;
            exp_rvalid <= 1'b0;
        end else begin
            exp_mis    <= 1'b0;
            exp_rvalid <= re;
            if (re) exp_rdata <= load_val(size, sign_ext, addr);
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (k < (1 << size)) m[((addr % NBYTES) + k) % NBYTES] <= wdata[8*k +: 8];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("busy", 32'(busy), 32'(sweep_left != 0));
            checkOutput("rvalid", 32'(rvalid), 32'(exp_rvalid));
            checkOutput("misalign", 32'(misalign), 32'(exp_mis));
            checkOutput("rdata", rdata, exp_rdata);
            checkOutput("test", 32'(test), 32'({m[1], m[0]}));
        end
    end

    // Presents one request for exactly one edge; returns just after that edge
    // so the registered response can be checked.
    task automatic applyStimulus(input logic w, input logic r, input logic [1:0] sz,
                                 input logic sx, input logic [31:0] a,
                                 input logic [31:0] d);
        we       = w;
        re       = r;
        size     = sz;
        sign_ext = sx;
        addr     = a;
        wdata    = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic countBusy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic checkAllZero(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'(4 * i), 32'h0);
            checkOutput({name, "_rvalid"}, 32'(rvalid), 32'h1);
            checkOutput({name, "_data"}, rdata, 32'h0);
        end
    endtask

    int          busy_cnt;
    logic [1:0]  r_size;
    logic [31:0] r_addr;

    initial begin
        // Reset held for three edges; reset-state literals.
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'h1);
        checkOutput("rst_rvalid", 32'(rvalid), 32'h0);
        checkOutput("rst_misalign", 32'(misalign), 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        checkOutput("rst_test", 32'(test), 32'h0);

        // Release with a store+load request held during the whole sweep.
        reset = 1'b1;
        we    = 1'b1;
        re    = 1'b1;
        size  = 2'b10;
        addr  = 32'h8;
        wdata = 32'hDEAD_BEEF;
        countBusy(busy_cnt);
        checkOutput("sweep_len", 32'(busy_cnt), 32'd16);
        checkAllZero("sweep_zero");

        // Byte/half stores and loads.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h1122_3344);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'hA, 32'h0000_00AA);
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h8, 32'h0000_BEEF);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0);
        checkOutput("lw_8", rdata, 32'h11AA_BEEF);
        checkOutput("model_lw_8", exp_rdata, 32'h11AA_BEEF);
        checkOutput("lw_8_valid", 32'(rvalid), 32'h1);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 32'hA, 32'h0);
        checkOutput("lb_a", rdata, 32'hFFFF_FFAA);
        checkOutput("model_lb_a", exp_rdata, 32'hFFFF_FFAA);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'hA, 32'h0);
        checkOutput("lbu_a", rdata, 32'h0000_00AA);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 32'h8, 32'h0);
        checkOutput("lh_8", rdata, 32'hFFFF_BEEF);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'hA, 32'h0);
        checkOutput("lhu_a", rdata, 32'h0000_11AA);

        // Misaligned / illegal accesses.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0102_0304);
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'hFFFF_FFFF);
        checkOutput("sw_6_mis", 32'(misalign), 32'h1);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h0);
        checkOutput("lh_3_mis", 32'(misalign), 32'h1);
        checkOutput("lh_3_rvalid", 32'(rvalid), 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0);
        checkOutput("sz11_mis", 32'(misalign), 32'h1);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0);
        checkOutput("lw_4_after_mis", rdata, 32'h0102_0304);
        checkOutput("lw_4_mis_clear", 32'(misalign), 32'h0);

        // Same-cycle read and write.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h5);
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h9);
        checkOutput("rbw_old", rdata, 32'h5);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
        checkOutput("rbw_new", rdata, 32'h9);

        // Address wrap and debug port.
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'hCAFE_1234);
        checkOutput("wrap_test", 32'(test), 32'h1234);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
        checkOutput("wrap_lw0", rdata, 32'hCAFE_1234);

        // Back-to-back loads; rvalid stays high.
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0);
        checkOutput("b2b_valid", 32'(rvalid), 32'h1);
        checkOutput("b2b_data", rdata, 32'h0102_0304);

        // Randomized traffic, mostly aligned, with some illegal sizes.
        for (int i = 0; i < 600; i++) begin
            r_size = 2'($urandom_range(0, 3));
            r_addr = $urandom();
            if (r_size != 2'b11 && $urandom_range(0, 3) != 0) begin
                r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
            end
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_size,
                          1'($urandom_range(0, 1)), r_addr, $urandom());
        end

        // Reset in the middle of the sweep restarts it from word 0.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        countBusy(busy_cnt);
        checkOutput("midsweep_len", 32'(busy_cnt), 32'd16);
        checkAllZero("midsweep_zero");

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
